// File: rtl/tick_monitor_pkg.sv
// Shared types and constants for the tick monitor and the clock-divider
// tick generators it observes.
package tick_monitor_pkg;

    localparam int unsigned TM_EXPECTED = 100000;
    localparam int unsigned TM_TOL      = 2;
    localparam int unsigned TM_LOCK_N   = 3;
    localparam int unsigned TM_CW       = 17;

    typedef enum logic [1:0] {
        TM_IDLE    = 2'd0,
        TM_ACQUIRE = 2'd1,
        TM_LOCKED  = 2'd2
    } tm_state_e;

    // Rearranged as period+tol >= expected so nothing is ever subtracted.
    function automatic logic tm_in_tol(
        input logic [32:0] period,
        input logic [32:0] expected,
        input logic [32:0] tol
    );
        logic [32:0] lo_sum;
        logic [32:0] hi_lim;
        lo_sum = period + tol;
        hi_lim = expected + tol;
        return (lo_sum >= expected) && (period <= hi_lim);
    endfunction

endpackage

// File: rtl/tick_monitor_edge_det.sv
// Rising-edge detector for the divider tick; a level held high fires once.
module tick_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    output logic tick_rise_o
);

    logic tick_q;

    // Delayed copy of the tick, updated every cycle regardless of clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_i;
        end
    end

    assign tick_rise_o = tick_i & ~tick_q;

endmodule

// File: rtl/tick_monitor.sv
// Measures the period between divider ticks, declares lock after a run of
// in-tolerance periods, and flags bad periods and missing ticks.
module tick_monitor
    import tick_monitor_pkg::*;
#(
    parameter int unsigned EXPECTED = TM_EXPECTED,
    parameter int unsigned TOL      = TM_TOL,
    parameter int unsigned LOCK_N   = TM_LOCK_N,
    parameter int unsigned CW       = TM_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick_in,
    input  logic          clear,
    output logic [CW-1:0] period,
    output logic          period_valid,
    output logic          locked,
    output logic          err,
    output logic          miss,
    output logic [7:0]    miss_cnt
);

    localparam logic [CW-1:0] TIMEOUT  = CW'(EXPECTED + TOL + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [4:0]    LOCK_N_W = 5'(LOCK_N);

    tm_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [3:0]    good_q, good_d;
    logic          pv_q, pv_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic          miss_q, miss_d;
    logic [7:0]    miss_cnt_q, miss_cnt_d;

    logic          tick_rise_s;
    logic          period_good_s;
    logic [4:0]    good_inc_s;

    tick_edge_det u_edge (
        .clk         (clk),
        .reset       (reset),
        .tick_i      (tick_in),
        .tick_rise_o (tick_rise_s)
    );

    assign period_good_s = tm_in_tol(33'(cnt_q), 33'(EXPECTED), 33'(TOL));
    assign good_inc_s    = {1'b0, good_q} + 5'd1;

    // Next-state and datapath: clear beats tick_rise, tick_rise beats timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        good_d     = good_q;
        pv_d       = 1'b0;
        err_d      = err_q;
        miss_d     = 1'b0;
        miss_cnt_d = miss_cnt_q;

        if (clear) begin
            state_d    = TM_IDLE;
            cnt_d      = '0;
            period_d   = '0;
            good_d     = 4'd0;
            err_d      = 1'b0;
            miss_cnt_d = 8'd0;
        end else begin
            case (state_q)
                TM_IDLE: begin
                    if (tick_rise_s) begin
                        state_d = TM_ACQUIRE;
                        cnt_d   = CNT_ONE;
                        good_d  = 4'd0;
                    end else begin
                        state_d = TM_IDLE;
                    end
                end
                TM_ACQUIRE, TM_LOCKED: begin
                    if (tick_rise_s) begin
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        cnt_d    = CNT_ONE;
                        if (period_good_s) begin
                            // Saturate so a long locked run cannot wrap and drop lock.
                            good_d = (good_q == 4'hF) ? good_q : good_inc_s[3:0];
                            if (good_inc_s >= LOCK_N_W) begin
                                state_d = TM_LOCKED;
                            end else begin
                                state_d = state_q;
                            end
                        end else begin
                            err_d   = 1'b1;
                            good_d  = 4'd0;
                            state_d = TM_ACQUIRE;
                        end
                    end else if (cnt_q == TIMEOUT) begin
                        miss_d     = 1'b1;
                        miss_cnt_d = (miss_cnt_q == 8'hFF) ? miss_cnt_q : miss_cnt_q + 8'd1;
                        good_d     = 4'd0;
                        state_d    = TM_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = TM_IDLE;
                end
            endcase
        end

        locked_d = (state_d == TM_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TM_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            good_q     <= 4'd0;
            pv_q       <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            miss_q     <= 1'b0;
            miss_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            good_q     <= good_d;
            pv_q       <= pv_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            miss_q     <= miss_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign err          = err_q;
    assign miss         = miss_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Directed bench for tick_monitor: a small configuration (10/1/3/8) for the
// protocol cases and a wide 17-bit configuration driven by a divider model.
module tb_tick_monitor;

    logic clk;
    logic reset;
    logic tick_in;
    logic clear;
    logic tick2;
    logic clear2;

    logic [7:0]  period1;
    logic        pv1, locked1, err1, miss1;
    logic [7:0]  mcnt1;

    logic [16:0] period2;
    logic        pv2, locked2, err2, miss2;
    logic [7:0]  mcnt2;

    int tests_run    = 0;
    int tests_failed = 0;

    tick_monitor #(.EXPECTED(10), .TOL(1), .LOCK_N(3), .CW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_in      (tick_in),
        .clear        (clear),
        .period       (period1),
        .period_valid (pv1),
        .locked       (locked1),
        .err          (err1),
        .miss         (miss1),
        .miss_cnt     (mcnt1)
    );

    // Default width/tolerance/lock count; period shortened to keep the run brief.
    tick_monitor #(.EXPECTED(1000)) dut_wide (
        .clk          (clk),
        .reset        (reset),
        .tick_in      (tick2),
        .clear        (clear2),
        .period       (period2),
        .period_valid (pv2),
        .locked       (locked2),
        .err          (err2),
        .miss         (miss2),
        .miss_cnt     (mcnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        tick_in = 1'b1;
        cyc(1);
        tick_in = 1'b0;
    endtask

    task automatic interval(input int k);
        cyc(k - 1);
        pulse();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        tick_in = 1'b0;
        clear   = 1'b0;
        tick2   = 1'b0;
        clear2  = 1'b0;
        cyc(2);
        check_eq("rst_period", 32'(period1), 32'd0);
        check_eq("rst_pv", 32'(pv1), 32'd0);
        check_eq("rst_locked", 32'(locked1), 32'd0);
        check_eq("rst_err", 32'(err1), 32'd0);
        check_eq("rst_miss", 32'(miss1), 32'd0);
        check_eq("rst_mcnt", 32'(mcnt1), 32'd0);
        check_eq("rst_wide_period", 32'(period2), 32'd0);
        reset = 1'b0;
        cyc(3);

        // Acquire and lock on four ticks spaced 10 apart.
        pulse();
        check_eq("t1_pv", 32'(pv1), 32'd0);
        check_eq("t1_locked", 32'(locked1), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            interval(10);
            check_eq("tn_period", 32'(period1), 32'd10);
            check_eq("tn_pv", 32'(pv1), 32'd1);
            check_eq("tn_locked", 32'(locked1), (i == 4) ? 32'd1 : 32'd0);
        end
        check_eq("t4_err", 32'(err1), 32'd0);
        cyc(1);
        check_eq("pv_drop", 32'(pv1), 32'd0);
        cyc(8);
        pulse();
        check_eq("t5_locked", 32'(locked1), 32'd1);

        // One long interval (tick exactly at the timeout count) breaks lock.
        interval(12);
        check_eq("long_period", 32'(period1), 32'd12);
        check_eq("long_err", 32'(err1), 32'd1);
        check_eq("long_locked", 32'(locked1), 32'd0);
        check_eq("long_miss", 32'(miss1), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            interval(10);
            check_eq("relock", 32'(locked1), (i == 3) ? 32'd1 : 32'd0);
        end
        check_eq("err_sticky", 32'(err1), 32'd1);

        // Tolerance edges 9/11 keep lock, 8 breaks it.
        do_clear();
        check_eq("clr_err", 32'(err1), 32'd0);
        check_eq("clr_period", 32'(period1), 32'd0);
        check_eq("clr_locked", 32'(locked1), 32'd0);
        pulse();
        check_eq("clr_t1_pv", 32'(pv1), 32'd0);
        for (int i = 0; i < 3; i++) interval(10);
        check_eq("b_locked", 32'(locked1), 32'd1);
        interval(9);
        check_eq("p9_period", 32'(period1), 32'd9);
        check_eq("p9_locked", 32'(locked1), 32'd1);
        interval(11);
        check_eq("p11_period", 32'(period1), 32'd11);
        check_eq("p11_locked", 32'(locked1), 32'd1);
        check_eq("p11_err", 32'(err1), 32'd0);
        interval(8);
        check_eq("p8_period", 32'(period1), 32'd8);
        check_eq("p8_err", 32'(err1), 32'd1);
        check_eq("p8_locked", 32'(locked1), 32'd0);

        // Missing tick from the locked state.
        for (int i = 0; i < 3; i++) interval(10);
        check_eq("c_locked", 32'(locked1), 32'd1);
        cyc(11);
        check_eq("miss_early", 32'(miss1), 32'd0);
        cyc(1);
        check_eq("miss_pulse", 32'(miss1), 32'd1);
        check_eq("miss_cnt1", 32'(mcnt1), 32'd1);
        check_eq("miss_locked", 32'(locked1), 32'd0);
        cyc(1);
        check_eq("miss_drop", 32'(miss1), 32'd0);
        pulse();
        check_eq("restart_pv", 32'(pv1), 32'd0);
        interval(10);
        check_eq("restart_period", 32'(period1), 32'd10);
        check_eq("restart_pv2", 32'(pv1), 32'd1);

        // Tick landing exactly at the timeout count is a bad period.
        do_clear();
        pulse();
        interval(12);
        check_eq("edge12_period", 32'(period1), 32'd12);
        check_eq("edge12_err", 32'(err1), 32'd1);
        check_eq("edge12_miss", 32'(miss1), 32'd0);
        check_eq("edge12_mcnt", 32'(mcnt1), 32'd0);

        // Five-cycle-wide ticks every 10 cycles count once per burst.
        do_clear();
        for (int b = 0; b < 4; b++) begin
            tick_in = 1'b1;
            cyc(1);
            check_eq("burst_pv", 32'(pv1), (b == 0) ? 32'd0 : 32'd1);
            if (b != 0) check_eq("burst_period", 32'(period1), 32'd10);
            cyc(1);
            check_eq("burst_hold_pv", 32'(pv1), 32'd0);
            cyc(3);
            tick_in = 1'b0;
            cyc(5);
        end
        check_eq("burst_locked", 32'(locked1), 32'd1);
        check_eq("burst_err", 32'(err1), 32'd0);

        // Clear together with a rising tick: tick ignored, held level no retrigger.
        tick_in = 1'b1;
        clear   = 1'b1;
        cyc(1);
        clear   = 1'b0;
        check_eq("ct_pv", 32'(pv1), 32'd0);
        check_eq("ct_locked", 32'(locked1), 32'd0);
        check_eq("ct_period", 32'(period1), 32'd0);
        check_eq("ct_err", 32'(err1), 32'd0);
        cyc(2);
        check_eq("ct_hold_pv", 32'(pv1), 32'd0);
        tick_in = 1'b0;
        cyc(3);
        pulse();
        check_eq("ct_idle_pv", 32'(pv1), 32'd0);

        // 300 timeouts saturate the miss counter.
        for (int i = 0; i < 300; i++) begin
            cyc(12);
            if (i == 0) check_eq("sat_miss0", 32'(miss1), 32'd1);
            if (i == 253) check_eq("sat_254", 32'(mcnt1), 32'd254);
            pulse();
        end
        check_eq("sat_255", 32'(mcnt1), 32'd255);

        // Asynchronous reset in the middle of an interval.
        interval(10);
        check_eq("pre_rst_period", 32'(period1), 32'd10);
        cyc(4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_period", 32'(period1), 32'd0);
        check_eq("arst_mcnt", 32'(mcnt1), 32'd0);
        check_eq("arst_locked", 32'(locked1), 32'd0);
        check_eq("arst_err", 32'(err1), 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(3);
        check_eq("post_rst_pv", 32'(pv1), 32'd0);
        check_eq("post_rst_miss", 32'(miss1), 32'd0);
        pulse();
        check_eq("post_rst_t1_pv", 32'(pv1), 32'd0);

        // Wide instance fed by a divider counting 0..999.
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc(999);
            tick2 = 1'b1;
            cyc(1);
            tick2 = 1'b0;
            check_eq("wide_pv", 32'(pv2), (k == 0) ? 32'd0 : 32'd1);
            if (k > 0) check_eq("wide_period", 32'(period2), 32'd1000);
            check_eq("wide_locked", 32'(locked2), (k == 3) ? 32'd1 : 32'd0);
        end
        check_eq("wide_err", 32'(err2), 32'd0);
        check_eq("wide_miss_cnt", 32'(mcnt2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tick_monitor.md
# tick_monitor

Checks the one-cycle tick pulses produced by the clock-divider tick generators in the MIPS_CPU design. It measures the clk-cycle period between ticks and reports each period. It declares lock after a run of in-tolerance periods, and flags out-of-tolerance periods and missing ticks. The block is the receiving end of the divider's tick interface and is used for on-board self-check and simulation monitoring of slow-clock/refresh ticks.

## Interface
- Clock `clk`; reset `reset`, asynchronous, active-high.
- EXPECTED, 100000: nominal tick period in clk cycles. This matches a divider counting 0..99999.
- TOL, 2: allowed deviation in cycles. A period passes if EXPECTED-TOL <= period <= EXPECTED+TOL.
- LOCK_N, 3: number of consecutive good periods required to lock (range 1..15).
- CW, 17: counter/period width. Requires EXPECTED+TOL+1 < 2^CW.
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- tick_in  in  1  tick from the divider, synchronous to clk. Only its rising edge counts.
- clear  in  1  synchronous clear of status and measurement.
- period  out  CW  last measured period.
- period_valid  out  1  one-cycle pulse when `period` updates.
- locked  out  1  high while in LOCKED state.
- err  out  1  sticky flag: an out-of-tolerance period was seen.
- miss  out  1  one-cycle pulse on timeout (no tick in time).
- miss_cnt  out  8  saturating count of timeouts.

## Operation
- Edge detect: tick_rise = tick_in & ~tick_d, where tick_d is tick_in registered. A level held high counts once.
- cnt (CW bits) counts cycles since the last tick_rise. It is set to 1 on tick_rise, increments each cycle in ACQUIRE/LOCKED, and holds in IDLE.
- good (4 bits) counts consecutive good periods.
- States:
  - IDLE: waiting for the first tick. On tick_rise: go to ACQUIRE, cnt<=1, good<=0, no period reported.
  - ACQUIRE and LOCKED, on tick_rise:
    - Always: period<=cnt, period_valid<=1, cnt<=1.
    - Good period: good<=good+1. If good+1 >= LOCK_N, go to (or stay in) LOCKED.
    - Bad period: err<=1, good<=0, go to ACQUIRE.
  - ACQUIRE and LOCKED, no tick_rise and cnt == EXPECTED+TOL+1: miss<=1, miss_cnt increments (saturating at 255), good<=0, go to IDLE.
- Priority, highest first:
  1. reset
  2. clear
  3. tick_rise
  4. timeout
- tick_rise in the same cycle that cnt reaches EXPECTED+TOL+1 is treated as a bad period (err set), not a miss.
- clear: go to IDLE; cnt, good, period, miss_cnt <= 0; err, period_valid, miss <= 0. A tick_rise in the same cycle is ignored, but tick_d still updates, so a level already high does not retrigger.
- Arithmetic is unsigned. The tolerance compare uses CW+1-bit intermediates so EXPECTED-TOL cannot underflow.

## Timing
- All outputs are registered.
- Reset values: period=0, period_valid=0, locked=0, err=0, miss=0, miss_cnt=0, state IDLE, tick_d=0, cnt=0, good=0.
- Latency: tick_in rising at clk edge t (sampled high at t, low at t-1) gives period/period_valid/locked/err visible after edge t, i.e. one cycle of latency.
- Period definition: ticks sampled at edges t0 and t1 give period = t1 - t0. The divider's ticks yield exactly EXPECTED.
- miss asserts after edge t0+EXPECTED+TOL+1 when no tick_rise has occurred since t0.
- Reset asserted mid-measurement: immediate return to reset values. No pulse is emitted on deassertion.

## Structure
- Package tick_monitor_pkg holds the state enum {IDLE, ACQUIRE, LOCKED}, the tolerance-check function, and the default EXPECTED/TOL constants shared with the divider.
- One natural sub-module: tick_edge_det (registered tick_d, tick_rise output). Everything else stays in one FSM+datapath module.

## Test plan
Use EXPECTED=10, TOL=1, LOCK_N=3, CW=8 unless noted.
- Ticks every 10 cycles from reset:
  - First tick: no period_valid.
  - Ticks 2-4: period=10 with period_valid pulses.
  - locked=1 in the cycle after tick 4; err=0.
- While locked, one interval of 12: period=12, err=1 (stays 1), locked=0. Then 3 intervals of 10 relock.
- Intervals of 9 and 11 keep lock; intervals of 8 and 12 set err.
- After a tick, no further tick:
  - miss pulses exactly 12 cycles later; miss_cnt=1; locked=0.
  - Next tick restarts acquisition without period_valid.
- Tick arriving exactly at cnt=12: period=12, err=1, no miss.
- tick_in held high 5 cycles, repeated every 10: counted once per burst, period=10.
- Edge cases:
  - clear with a simultaneous tick_rise: all status 0, state IDLE.
  - 300 timeouts: miss_cnt saturates at 255.
  - reset mid-interval: outputs return to 0 the same cycle.
- Default parameters driven by a 100000-cycle divider model: period=100000; locked after the 4th tick.
